// File: rtl/dac_sched.sv
// dac_sched: keeps a dual 12-bit SPI DAC in step with two requested codes.
// A channel is resent when its requested code differs from the last code
// written, or when a forced write is outstanding after reset. When both
// channels are pending, the channel not served last wins. Frames are 16 bits,
// SPI mode 0, MSB first.
// Optional feature macro: DAC_SCHED_LDAC_EN. When defined, an LDAC strobe
// follows each frame. When undefined, ldac_n is tied low.
module dac_sched #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] aout0,
    input  logic [11:0] aout1,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        ldac_n,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
`ifdef DAC_SCHED_LDAC_EN
    localparam logic [1:0] ST_LATCH = 2'd3;
`endif

    // The counter is 9 bits wide so that it can hold the longest gap,
    // 2*255-1 = 509, without wrapping.
    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    logic [1:0]  state;
    logic [11:0] sent0, sent1;
    logic        force0, force1;
    logic        last_grant;      // 0 = channel A, 1 = channel B
    logic        grant;           // channel of the frame in flight
    logic [11:0] snap;            // code of the frame in flight
    logic [15:0] shreg;           // shifted frame, bit 15 is on mosi
    logic [3:0]  bit_cnt;         // bits still to send after the current one
    logic [8:0]  cnt;             // cycle counter within a phase
    logic        sclk_q, cs_n_q, mosi_q;

    logic        pend0, pend1, grant_next;
    logic [11:0] code_next;

    // Pending flags and arbitration for the next frame.
    always_comb begin
        // NOTE: every signal is assigned unconditionally here, so no path leaves a
        // value held over and no latch is inferred.
        pend0      = force0 | (aout0 != sent0);
        pend1      = force1 | (aout1 != sent1);
        grant_next = (pend0 && pend1) ? ~last_grant : pend1;
        code_next  = grant_next ? aout1 : aout0;
    end

    // Frame sequencer: grants a channel, shifts its frame out, then holds the gap.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments. Each register
        // therefore sees the values from before this edge, whatever the statement order.
        if (rst) begin
            state      <= ST_IDLE;
            sent0      <= 12'd0;
            sent1      <= 12'd0;
            force0     <= 1'b1;
            force1     <= 1'b1;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            snap       <= 12'd0;
            shreg      <= 16'd0;
            bit_cnt    <= 4'd0;
            cnt        <= 9'd0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend0 || pend1) begin
                        grant   <= grant_next;
                        snap    <= code_next;
                        shreg   <= {grant_next, 3'b011, code_next};
                        mosi_q  <= grant_next;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        bit_cnt <= 4'd15;
                        cnt     <= 9'd0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= 9'd0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bit_cnt == 4'd0) begin
                            sclk_q     <= 1'b0;
                            cs_n_q     <= 1'b1;
                            mosi_q     <= 1'b0;
                            last_grant <= grant;
                            if (grant) begin
                                sent1  <= snap;
                                force1 <= 1'b0;
                            end else begin
                                sent0  <= snap;
                                force0 <= 1'b0;
                            end
                            state <= ST_GAP;
                        end else begin
                            sclk_q  <= 1'b0;
                            shreg   <= {shreg[14:0], 1'b0};
                            mosi_q  <= shreg[14];
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 9'd0;
`ifdef DAC_SCHED_LDAC_EN
                        state <= ST_LATCH;
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
`ifdef DAC_SCHED_LDAC_EN
                ST_LATCH: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= 9'd0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DAC_SCHED_LDAC_EN
    logic ldac_q;

    // LDAC strobe: low for the whole of the LATCH state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ldac_q <= 1'b1;
        end else if (state == ST_GAP && cnt == GAP_LAST) begin
            ldac_q <= 1'b0;
        end else if (state == ST_LATCH && cnt == HALF_LAST) begin
            ldac_q <= 1'b1;
        end
    end

    assign ldac_n = ldac_q;
`else
    // DAC runs in transparent update mode, so the latch strobe is held low.
    assign ldac_n = 1'b0;
`endif

    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dac_sched.sv
// tb_dac_sched: directed test of dac_sched with CLK_DIV = 2.
// A negedge monitor rebuilds each SPI frame from mosi on the sclk rising edges.
// It also measures cs_n low and high times and the timing of the ldac_n strobe.
module tb_dac_sched;

    localparam int CLK_DIV = 2;

    logic        clk;
    logic        rst;
    logic [11:0] aout0, aout1;
    logic        cs_n, sclk, mosi, ldac_n, busy;

    int checks;
    int errors;

    dac_sched #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .aout0 (aout0),
        .aout1 (aout1),
        .cs_n  (cs_n),
        .sclk  (sclk),
        .mosi  (mosi),
        .ldac_n(ldac_n),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor state
    logic [15:0] frames[$];
    int          lows[$];
    int          gaps[$];
    int          frame_starts;
    int          bits_in_frame;
    bit          in_frame;
    logic [15:0] shift_q;
    int          low_cnt, hi_cnt, since_rise;
    logic        prev_sclk, prev_ldac;
    int          ldac_start, ldac_len;
    bit          ldac_bad;

    initial begin
        frame_starts = 0;
        ldac_bad     = 1'b0;
        ldac_start   = -1;
        ldac_len     = 0;
        prev_ldac    = 1'b1;
    end

    // Frame and strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            in_frame      = 1'b0;
            low_cnt       = 0;
            hi_cnt        = 0;
            since_rise    = 0;
            bits_in_frame = 0;
            prev_sclk     = 1'b0;
        end else begin
            if (!cs_n) begin
                if (!in_frame) begin
                    in_frame      = 1'b1;
                    low_cnt       = 0;
                    shift_q       = 16'd0;
                    bits_in_frame = 0;
                    gaps.push_back(hi_cnt);
                    frame_starts++;
                end
                low_cnt++;
                if (sclk && !prev_sclk) begin
                    shift_q = {shift_q[14:0], mosi};
                    bits_in_frame++;
                end
            end else begin
                if (in_frame) begin
                    frames.push_back(shift_q);
                    lows.push_back(low_cnt);
                    in_frame   = 1'b0;
                    hi_cnt     = 0;
                    since_rise = 1;
                end else begin
                    since_rise++;
                end
                hi_cnt++;
            end
            prev_sclk = sclk;
`ifdef DAC_SCHED_LDAC_EN
            if (!ldac_n && prev_ldac) begin
                ldac_start = since_rise - 1;
                ldac_len   = 0;
            end
            if (!ldac_n) ldac_len++;
`else
            if (ldac_n !== 1'b0) ldac_bad = 1'b1;
`endif
        end
        prev_ldac = ldac_n;
    end

    task automatic clear_mon();
        frames.delete();
        lows.delete();
        gaps.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (frames.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (frames.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d frames, required %0d", name, frames.size(), n);
        end
    endtask

    task automatic wait_start(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (frame_starts < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (frame_starts < target) begin
            errors++;
            $display("FAIL %s start timeout: starts %0d, required %0d", name, frame_starts, target);
        end
    endtask

    // Compare frame k of the queue against an expected value and length.
    task automatic check_frame(input int k, input logic [15:0] exp, input string name);
        checks++;
        if (k >= frames.size()) begin
            errors++;
            $display("FAIL %s missing frame %0d", name, k);
        end else begin
            if (frames[k] !== exp) begin
                errors++;
                $display("FAIL %s frame %0d: got 0x%04h, required 0x%04h", name, k, frames[k], exp);
            end
            checks++;
            if (lows[k] != 32 * CLK_DIV) begin
                errors++;
                $display("FAIL %s cs_n low %0d: got %0d cycles, required %0d", name, k, lows[k], 32 * CLK_DIV);
            end
        end
    endtask

    // Idle for a while, then confirm that no extra frame appeared and busy is low.
    task automatic check_quiet(input int n, input string name);
        repeat (200) @(negedge clk);
        checks++;
        if (frames.size() != n) begin
            errors++;
            $display("FAIL %s frame count: got %0d, required %0d", name, frames.size(), n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after idle: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        aout0 = 12'h000;
        aout1 = 12'h000;
        repeat (4) @(negedge clk);
        checks++;
        if ({cs_n, sclk, mosi, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset outputs cs_n/sclk/mosi/busy: got %b, required 1000", {cs_n, sclk, mosi, busy});
        end
        checks++;
`ifdef DAC_SCHED_LDAC_EN
        if (ldac_n !== 1'b1) begin
            errors++;
            $display("FAIL reset ldac_n: got %b, required 1", ldac_n);
        end
`else
        if (ldac_n !== 1'b0) begin
            errors++;
            $display("FAIL reset ldac_n: got %b, required 0", ldac_n);
        end
`endif
    endtask

    task automatic test_post_reset();
        clear_mon();
        rst = 1'b0;
        wait_frames(2, 600, "post_reset");
        check_frame(0, 16'h3000, "post_reset");
        check_frame(1, 16'hB000, "post_reset");
        checks++;
        if (gaps.size() < 2 || gaps[1] < 2 * CLK_DIV) begin
            errors++;
            $display("FAIL post_reset gap: got %0d, required >= %0d", (gaps.size() < 2) ? -1 : gaps[1], 2 * CLK_DIV);
        end
        check_quiet(2, "post_reset");
    endtask

    task automatic test_single();
        int s;
        clear_mon();
        s = frame_starts;
        aout1 = 12'hABC;
        wait_start(s + 1, 50, "single");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single busy in frame: got %b, required 1", busy);
        end
        wait_frames(1, 300, "single");
        check_frame(0, 16'hBABC, "single");
        check_quiet(1, "single");
    endtask

    task automatic test_both();
        clear_mon();
        aout0 = 12'h123;
        aout1 = 12'h456;
        wait_frames(2, 600, "both_b_last");
        check_frame(0, 16'h3123, "both_b_last");
        check_frame(1, 16'hB456, "both_b_last");
        check_quiet(2, "both_b_last");
        // Make A the last grant, then change both channels together.
        clear_mon();
        aout0 = 12'h555;
        wait_frames(1, 300, "both_prep");
        check_frame(0, 16'h3555, "both_prep");
        check_quiet(1, "both_prep");
        clear_mon();
        aout0 = 12'h777;
        aout1 = 12'h888;
        wait_frames(2, 600, "both_a_last");
        check_frame(0, 16'hB888, "both_a_last");
        check_frame(1, 16'h3777, "both_a_last");
        check_quiet(2, "both_a_last");
    endtask

    task automatic test_mid_frame();
        int s;
        clear_mon();
        s = frame_starts;
        aout0 = 12'h100;
        wait_start(s + 1, 50, "mid_frame");
        repeat (10) @(negedge clk);
        aout0 = 12'h200;
        repeat (10) @(negedge clk);
        aout0 = 12'h300;
        wait_frames(2, 600, "mid_frame");
        check_frame(0, 16'h3100, "mid_frame");
        check_frame(1, 16'h3300, "mid_frame");
        check_quiet(2, "mid_frame");
    endtask

    task automatic test_revert();
        int s;
        clear_mon();
        s = frame_starts;
        aout0 = 12'h400;
        wait_start(s + 1, 50, "revert");
        repeat (5) @(negedge clk);
        aout1 = 12'h111;
        repeat (5) @(negedge clk);
        aout1 = 12'h888;
        wait_frames(1, 300, "revert");
        check_frame(0, 16'h3400, "revert");
        check_quiet(1, "revert");
    endtask

    task automatic test_back_to_back();
        int s;
        clear_mon();
        s = frame_starts;
        aout0 = 12'h600;
        aout1 = 12'h700;
        for (int k = 1; k <= 3; k++) begin
            wait_start(s + k, 300, "alternate");
            aout0 = 12'h600 + 12'(k);
            aout1 = 12'h700 + 12'(k);
        end
        wait_frames(5, 1500, "alternate");
        check_frame(0, 16'hB700, "alternate");
        check_frame(1, 16'h3601, "alternate");
        check_frame(2, 16'hB702, "alternate");
        check_frame(3, 16'h3603, "alternate");
        check_frame(4, 16'hB703, "alternate");
        check_quiet(5, "alternate");
    endtask

    task automatic test_reset_mid();
        int s, t;
        clear_mon();
        s = frame_starts;
        aout1 = 12'h321;
        wait_start(s + 1, 50, "reset_mid");
        t = 0;
        while (bits_in_frame < 9 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bits_in_frame < 9) begin
            errors++;
            $display("FAIL reset_mid bit wait: got %0d bits, required 9", bits_in_frame);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs_n, sclk, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid abort cs_n/sclk/busy: got %b, required 100", {cs_n, sclk, busy});
        end
        repeat (3) @(negedge clk);
        clear_mon();
        rst = 1'b0;
        wait_frames(2, 600, "reset_mid");
        check_frame(0, 16'h3603, "reset_mid");
        check_frame(1, 16'hB321, "reset_mid");
        check_quiet(2, "reset_mid");
    endtask

    task automatic test_ldac();
`ifdef DAC_SCHED_LDAC_EN
        checks++;
        if (ldac_start != 2 * CLK_DIV) begin
            errors++;
            $display("FAIL ldac start: got %0d cycles after cs_n rise, required %0d", ldac_start, 2 * CLK_DIV);
        end
        checks++;
        if (ldac_len != CLK_DIV) begin
            errors++;
            $display("FAIL ldac width: got %0d cycles, required %0d", ldac_len, CLK_DIV);
        end
`else
        checks++;
        if (ldac_bad) begin
            errors++;
            $display("FAIL ldac tied low: got a non-zero ldac_n, required 0 throughout");
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_post_reset();
        test_single();
        test_both();
        test_mid_frame();
        test_revert();
        test_back_to_back();
        test_reset_mid();
        test_ldac();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
